// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with match threshold sequencing
// Optional SEQ_DET_NONOVERLAP_EN clears the window fill on every match
module seq_det_ctrl #(
   parameter int MAXLEN = 8,
   parameter int LEN_W  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [CNT_W-1:0]  cfg_thresh,
   input  logic              start,
   input  logic              stop,
   input  logic              x_valid,
   input  logic              x,
   output logic              z,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  match_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state_q, state_d;
   logic [MAXLEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_n, mask;
   logic [LEN_W-1:0]  len_q, len_d, fill_q, fill_d, fill_n;
   logic [CNT_W-1:0]  thr_q, thr_d, cnt_q, cnt_d;
   logic              z_q, z_d, err_q, err_d;
   logic              wr, cfg_ok, arm, shift, match, hit;

   assign wr     = cfg_we && state_q == IDLE;
   assign cfg_ok = len_q != '0 && len_q <= LEN_W'(MAXLEN) && thr_q != '0;
   assign arm    = start && !stop && ((state_q == IDLE && cfg_ok) || state_q == DONE);
   assign shift  = state_q == RUN && x_valid && !stop;
   assign hist_n = (hist_q << 1) | MAXLEN'(x);
   assign mask   = ~({MAXLEN{1'b1}} << len_q);
   assign match  = shift && fill_q >= len_q - 1'b1 && ((hist_n ^ pat_q) & mask) == '0;
   assign hit    = match && cnt_q + 1'b1 == thr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         thr_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         thr_q   <= thr_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = stop ? IDLE : arm ? RUN : hit ? DONE : state_q;
   end

   always_comb begin
      pat_d  = wr ? cfg_pattern : pat_q;
      len_d  = wr ? cfg_len : len_q;
      thr_d  = wr ? cfg_thresh : thr_q;
`ifdef SEQ_DET_NONOVERLAP_EN
      fill_n = match ? '0 : fill_q < len_q ? fill_q + 1'b1 : len_q;
`else
      fill_n = fill_q < len_q ? fill_q + 1'b1 : len_q;
`endif
      hist_d = arm ? '0 : shift ? hist_n : hist_q;
      fill_d = arm ? '0 : shift ? fill_n : fill_q;
      cnt_d  = arm ? '0 : match ? cnt_q + 1'b1 : cnt_q;
      z_d    = match;
      err_d  = start && !stop && state_q == IDLE && !cfg_ok;
   end

   assign z         = z_q;
   assign cfg_err   = err_q;
   assign match_cnt = cnt_q;
   assign busy      = state_q == RUN;
   assign done      = state_q == DONE;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;
   logic       clk = 0, reset = 0, cfg_we = 0, start = 0, stop = 0, x_valid = 0, x = 0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic [7:0] cfg_thresh = '0;
   logic       z, busy, done, cfg_err;
   logic [7:0] match_cnt;
   int         checks = 0, fails = 0;
   logic       ov_b [7] = '{1, 1, 0, 1, 1, 0, 1};
   logic       ov_z [7] = '{0, 0, 0, 1, 0, 0, 1};
   logic       pb [4] = '{1, 1, 0, 1};

   seq_det_ctrl dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
      .x_valid(x_valid), .x(x), .z(z), .busy(busy), .done(done),
      .cfg_err(cfg_err), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
      cfg_pattern = p;
      cfg_len = l;
      cfg_thresh = t;
      cfg_we = 1;
      step();
      cfg_we = 0;
   endtask

   task automatic go();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic bit_in(input logic b);
      x_valid = 1;
      x = b;
      step();
      x_valid = 0;
   endtask

   initial begin
      #2;
      check("rst_z", z, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", cfg_err, 0);
      check("rst_cnt", match_cnt, 0);
      step();
      step();
      reset = 1;
      step();
      // overlapping detection, with an ignored cfg write while running
      cfg(8'b1101, 4, 2);
      go();
      check("ov_busy", busy, 1);
      check("ov_cnt0", match_cnt, 0);
      for (int i = 0; i < 7; i++) begin
         if (i == 4) begin
            cfg_pattern = '0;
            cfg_len = '0;
            cfg_we = 1;
         end
         bit_in(ov_b[i]);
         cfg_we = 0;
         check($sformatf("ov_z%0d", i), z, ov_z[i]);
      end
      check("ov_cnt", match_cnt, 2);
      check("ov_done", done, 1);
      check("ov_busy_end", busy, 0);
      step();
      check("ov_zoff", z, 0);
      bit_in(1);
      bit_in(1);
      check("dn_frozen", match_cnt, 2);
      check("dn_noz", z, 0);
      start = 1;
      stop = 1;
      step();
      start = 0;
      stop = 0;
      check("ss_done", done, 0);
      check("ss_busy", busy, 0);
      check("ss_cnt", match_cnt, 2);
      // config errors
      cfg(8'b1101, 0, 1);
      go();
      check("err_len0", cfg_err, 1);
      check("err_len0_busy", busy, 0);
      step();
      check("err_pulse", cfg_err, 0);
      cfg(8'b1101, 4, 0);
      go();
      check("err_thr0", cfg_err, 1);
      cfg(8'b1101, 9, 1);
      go();
      check("err_len9", cfg_err, 1);
      check("err_len9_busy", busy, 0);
      cfg_len = 4;
      cfg_thresh = 1;
      cfg_we = 1;
      start = 1;
      step();
      cfg_we = 0;
      start = 0;
      check("err_old", cfg_err, 1);
      check("err_old_busy", busy, 0);
      go();
      check("new_busy", busy, 1);
      check("new_err", cfg_err, 0);
      // gapped input
      for (int i = 0; i < 4; i++) begin
         bit_in(pb[i]);
         check($sformatf("gap_z%0d", i), z, i == 3);
         if (i < 3)
            for (int j = 0; j < 3; j++) begin
               step();
               check($sformatf("gap_idle%0d_%0d", i, j), z, 0);
            end
      end
      check("gap_cnt", match_cnt, 1);
      check("gap_done", done, 1);
      step();
      check("gap_zoff", z, 0);
      // restart from DONE clears count and window
      go();
      check("rs_busy", busy, 1);
      check("rs_cnt", match_cnt, 0);
      bit_in(1);
      bit_in(0);
      bit_in(1);
      check("rs_nofill", z, 0);
      stop = 1;
      step();
      stop = 0;
      check("rs_stop", busy, 0);
      // stop in RUN retains count and suppresses the stop-cycle match
      cfg(8'b1101, 4, 3);
      go();
      for (int i = 0; i < 4; i++) bit_in(pb[i]);
      check("st_z", z, 1);
      check("st_cnt1", match_cnt, 1);
      bit_in(1);
      bit_in(0);
      x_valid = 1;
      x = 1;
      stop = 1;
      step();
      stop = 0;
      x_valid = 0;
      check("st_noz", z, 0);
      check("st_busy", busy, 0);
      check("st_cnt", match_cnt, 1);
      // asynchronous reset mid-run
      go();
      check("rr_busy", busy, 1);
      check("rr_cnt0", match_cnt, 0);
      for (int i = 0; i < 4; i++) bit_in(pb[i]);
      check("rr_zpre", z, 1);
      #2;
      reset = 0;
      #1;
      check("rr_z", z, 0);
      check("rr_busy0", busy, 0);
      check("rr_cnt", match_cnt, 0);
      check("rr_done", done, 0);
      #3;
      reset = 1;
      step();
      go();
      check("rr_shadow", cfg_err, 1);
      cfg(8'b1101, 4, 3);
      go();
      check("rr_run", busy, 1);
      bit_in(1);
      check("rr_bit1", z, 0);
      check("rr_bit1_cnt", match_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
